// File: rtl/acc_core_pkg.sv
// Shared types and constants for the accumulator core: opcode set, FSM states
// and the opcode field width.
package acc_core_pkg;

  localparam int unsigned OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_LDA = 3'b100,
    OP_STA = 3'b101,
    OP_JMP = 3'b110,
    OP_JZ  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_HALT
  } state_e;

endpackage

// File: rtl/acc_core_alu.sv
// Combinational accumulator ALU; arithmetic wraps modulo 2^DW, no flags.
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] acc_i,
  input  logic [DW-1:0] mdr_i,
  input  opcode_e       opcode_i,
  output logic [DW-1:0] result_o
);

  always_comb begin
    result_o = acc_i;
    case (opcode_i)
      OP_ADD:  result_o = acc_i + mdr_i;
      OP_SUB:  result_o = acc_i - mdr_i;
      OP_AND:  result_o = acc_i & mdr_i;
      OP_NOT:  result_o = ~acc_i;
      OP_LDA:  result_o = mdr_i;
      default: result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/MEM/EXEC/HALT over an external
// req/ack memory port.
module acc_core
  import acc_core_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned PC_RST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-4:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] acc_o,
  output logic [DW-4:0] pc_o,
  output logic          zero,
  output logic          halted
);

  localparam int unsigned AW = DW - OPW;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;

  opcode_e       opc;
  logic [AW-1:0] ir_addr;
  logic [AW-1:0] pc_prev;
  logic [DW-1:0] alu_res;

  assign opc     = opcode_e'(ir_q[DW-1 -: OPW]);
  assign ir_addr = ir_q[AW-1:0];
  assign pc_prev = pc_q - AW'(1);

  acc_core_alu #(.DW(DW)) u_alu (
    .acc_i    (acc_q),
    .mdr_i    (mdr_q),
    .opcode_i (opc),
    .result_o (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= AW'(PC_RST);
      acc_q   <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opc)
          OP_NOT: state_d = ST_EXEC;
          OP_JMP: begin
            // pc already points past this JMP, so a jump to pc-1 is a self-loop
            pc_d    = ir_addr;
            state_d = (ir_addr == pc_prev) ? ST_HALT : ST_FETCH;
          end
          OP_JZ: begin
            if (zero) pc_d = ir_addr;
            state_d = ST_FETCH;
          end
          default: state_d = ST_MEM;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (opc == OP_STA) begin
            state_d = ST_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        acc_d   = alu_res;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Request is gated by rst_n so it drops asynchronously and rises in the
  // first cycle after release without waiting for a clock edge.
  always_comb begin
    mem_req   = rst_n && ((state_q == ST_FETCH) || (state_q == ST_MEM));
    mem_we    = (state_q == ST_MEM) && (opc == OP_STA);
    mem_addr  = (state_q == ST_MEM) ? ir_addr : pc_q;
    mem_wdata = acc_q;
    halted    = (state_q == ST_HALT);
  end

  assign acc_o = acc_q;
  assign pc_o  = pc_q;
  assign zero  = (acc_q == '0);

endmodule

// File: doc/acc_core.md
ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 Parameter DW, default 16, data/instruction word width; legal range 8..32.
REQ-002 Parameter PC_RST, default 0, PC value after reset; AW = DW-3 is a derived localparam (address width).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 mem_req  output  1  memory transfer request; held high until acknowledged.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  AW  transfer address; valid while mem_req=1.
REQ-008 mem_wdata  output  DW  store data (accumulator); valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  input  DW  read data; sampled on the edge where mem_ack=1.
REQ-010 mem_ack  input  1  transfer completes on the rising edge where mem_req=1 and mem_ack=1.
REQ-011 acc_o  output  DW  accumulator value.
REQ-012 pc_o  output  AW  program counter value.
REQ-013 zero  output  1  combinational: acc_o == 0.
REQ-014 halted  output  1  high while in HALT state.

Function
REQ-015 Instruction word: opcode = bits [DW-1:DW-3], operand address = bits [AW-1:0].
REQ-016 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 LDA, 101 STA, 110 JMP, 111 JZ.
REQ-017 FSM states: FETCH, DECODE, MEM, EXEC, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on ack: IR <= mem_rdata, pc <= pc+1 mod 2^AW, go DECODE; otherwise stay.
REQ-019 DECODE: ADD/SUB/AND/LDA/STA -> MEM; NOT -> EXEC; JMP -> pc <= addr, then FETCH; JZ -> pc <= addr if zero, then FETCH.
REQ-020 JMP whose target equals its own address (pc-1 mod 2^AW) -> HALT instead of FETCH; pc still loaded with target.
REQ-021 MEM: mem_req=1, mem_addr=IR addr; STA: mem_we=1, mem_wdata=acc, go FETCH on ack; others: MDR <= mem_rdata, go EXEC on ack.
REQ-022 EXEC: ADD acc <= acc+MDR; SUB acc <= acc-MDR; AND acc <= acc&MDR; NOT acc <= ~acc; LDA acc <= MDR; then FETCH.
REQ-023 Arithmetic is modulo 2^DW; carry/borrow discarded; no overflow flag.
REQ-024 mem_ack while mem_req=0 is ignored; ack may arrive in the first request cycle (zero wait).
REQ-025 mem_req, mem_we, mem_addr, mem_wdata remain stable from request assertion until the acknowledging edge.
REQ-026 Zero-wait latency: ADD/SUB/AND/LDA 4 cycles, STA 3, NOT 3, JMP/JZ 2; each wait cycle adds one.
REQ-027 HALT: mem_req=0, no state change; exits only via reset.
REQ-028 accumulator is written only in EXEC; pc only in FETCH and DECODE.

Reset
REQ-029 rst_n low asynchronously forces: state FETCH, pc=PC_RST, acc=0, IR=0, MDR=0, halted=0, mem_req=0.
REQ-030 Reset mid-transfer abandons the transfer; mem_req drops asynchronously; first request after release is a fetch from PC_RST.
REQ-031 First mem_req assertion occurs in the first cycle after rst_n deasserts.

Structure
REQ-032 Shared package acc_core_pkg holds opcode enum, FSM state enum and opcode-width constant (3).
REQ-033 One sub-module acc_core_alu: combinational, DW-parametrised, inputs acc, MDR, opcode; output result.
REQ-034 Memory is external; block contains no storage array.

Verification
REQ-035 DW=16, zero-wait memory: mem[0]=LDA 10, mem[1]=ADD 11, mem[2]=STA 12, mem[3]=JMP 3, mem[10]=0x0005, mem[11]=0x0007 -> mem[12]=0x000C, halted=1, pc_o=3.
REQ-036 Same program, random 0..3 wait cycles on every ack -> identical final memory and halted; request signals stable across waits.
REQ-037 LDA of 0x0003, SUB of 0x0004 -> acc_o=0xFFFF, zero=0; then ADD of 0x0001 -> acc_o=0x0000, zero=1.
REQ-038 JZ 20 with acc=0 -> next fetch address 20; JZ 20 with acc=5 -> next fetch address = JZ address+1.
REQ-039 PC_RST=2^13-1, mem[8191]=NOT -> after it, fetch address 0 (wrap), acc_o=0xFFFF.
REQ-040 rst_n pulsed low during a stalled MEM read -> mem_req low immediately, acc_o=0, first post-reset fetch at PC_RST.
